// File: rtl/cia_pkg.sv
// -----------------------------------------------------------------------------
// cia_pkg
// Shared constants and types for the pipelined carry-increment adder.
//   CIA_WIDTH : full operand width (even)
//   CIA_HALF  : block width, one half of the operand
//   half_t    : one half-width block of an operand or sum
// -----------------------------------------------------------------------------
package cia_pkg;

    localparam int CIA_WIDTH = 32;
    localparam int CIA_HALF  = CIA_WIDTH / 2;

    typedef logic [CIA_HALF-1:0] half_t;

endpackage : cia_pkg

// File: rtl/cia32_pipe_if.sv
// -----------------------------------------------------------------------------
// cia32_pipe_if
// Operand / result handshake bundle for cia32_pipe.
//   in_valid, a, b, cin   : operand beat offered by the producer
//   in_ready              : adder can take the operand beat this cycle
//   out_valid, sum, cout  : result beat offered to the consumer
//   out_ready             : consumer takes the result beat this cycle
//   ovf                   : signed overflow, only when CIA_OVF_EN is defined
// Modports: master = producer/consumer side, slave = the adder.
// Optional feature macro: CIA_OVF_EN
// -----------------------------------------------------------------------------
interface cia32_pipe_if;
    import cia_pkg::*;

    logic                 in_valid;
    logic                 in_ready;
    logic [CIA_WIDTH-1:0] a;
    logic [CIA_WIDTH-1:0] b;
    logic                 cin;
    logic                 out_valid;
    logic                 out_ready;
    logic [CIA_WIDTH-1:0] sum;
    logic                 cout;
`ifdef CIA_OVF_EN
    logic                 ovf;

    modport master (
        output in_valid, a, b, cin, out_ready,
        input  in_ready, out_valid, sum, cout, ovf
    );
    modport slave (
        input  in_valid, a, b, cin, out_ready,
        output in_ready, out_valid, sum, cout, ovf
    );
`else
    modport master (
        output in_valid, a, b, cin, out_ready,
        input  in_ready, out_valid, sum, cout
    );
    modport slave (
        input  in_valid, a, b, cin, out_ready,
        output in_ready, out_valid, sum, cout
    );
`endif

endinterface : cia32_pipe_if

// File: rtl/incr16.sv
// -----------------------------------------------------------------------------
// incr16
// Combinational half-width incrementer used to fold the low-half carry into
// the upper-half partial sum.
//   a    in  : half-width value
//   cin  in  : increment enable (adds 1 when set)
//   sum  out : a + cin, modulo 2^CIA_HALF
//   cout out : carry out, only possible when a is all ones
// -----------------------------------------------------------------------------
module incr16
    import cia_pkg::*;
(
    input  half_t a,
    input  logic  cin,
    output half_t sum,
    output logic  cout
);

    assign sum  = a + half_t'(cin);
    assign cout = (&a) & cin;

endmodule : incr16

// File: rtl/cia32_pipe.sv
// -----------------------------------------------------------------------------
// cia32_pipe
// Two-stage pipelined carry-increment adder for the ALU32 datapath.
//   Stage 1 registers the low-half sum with its carry and the upper-half
//   partial sum computed with no carry in.
//   Stage 2 folds the low-half carry into the upper half with incr16.
// Ports:
//   clk    in : rising-edge clock
//   rst_n  in : asynchronous active-low reset
//   bus       : cia32_pipe_if.slave (valid/ready operand and result beats)
// Optional feature macro: CIA_OVF_EN adds the registered signed overflow flag.
// Latency is two cycles from operand transfer to out_valid; one beat per cycle.
// -----------------------------------------------------------------------------
module cia32_pipe
    import cia_pkg::*;
(
    input logic         clk,
    input logic         rst_n,
    cia32_pipe_if.slave bus
);

    logic adv1;
    logic adv2;
    logic xfer;

    logic vld_p1_q;
    logic vld_p2_q;

    half_t lo_sum_p1_q, lo_sum_p1_d;
    half_t hi_sum0_p1_q, hi_sum0_p1_d;
    logic  c_lo_p1_q, c_lo_p1_d;
    logic  c_hi0_p1_q, c_hi0_p1_d;

    logic [CIA_WIDTH-1:0] sum_p2_q, sum_p2_d;
    logic                 cout_p2_q, cout_p2_d;

    half_t hi_inc;
    logic  inc_cout;

`ifdef CIA_OVF_EN
    logic sa_p1_q, sb_p1_q;
    logic ovf_p2_q, ovf_p2_d;
`endif

    // A stage may advance when it is empty or the stage after it drains,
    // so a full pipe can drain and accept in the same cycle.
    assign adv2 = !vld_p2_q || bus.out_ready;
    assign adv1 = !vld_p1_q || adv2;
    assign xfer = bus.in_valid && adv1;

    assign bus.in_ready  = adv1;
    assign bus.out_valid = vld_p2_q;
    assign bus.sum       = sum_p2_q;
    assign bus.cout      = cout_p2_q;
`ifdef CIA_OVF_EN
    assign bus.ovf       = ovf_p2_q;
`endif

    // ---- stage 1: independent half sums -------------------------------------
    always_comb begin
        {c_lo_p1_d, lo_sum_p1_d} = {1'b0, bus.a[CIA_HALF-1:0]}
                                 + {1'b0, bus.b[CIA_HALF-1:0]}
                                 + {{CIA_HALF{1'b0}}, bus.cin};
        {c_hi0_p1_d, hi_sum0_p1_d} = {1'b0, bus.a[CIA_WIDTH-1:CIA_HALF]}
                                   + {1'b0, bus.b[CIA_WIDTH-1:CIA_HALF]};
    end

    // ---- stage 2: carry increment of the upper half -------------------------
    incr16 u_incr16 (
        .a    (hi_sum0_p1_q),
        .cin  (c_lo_p1_q),
        .sum  (hi_inc),
        .cout (inc_cout)
    );

    // hi_sum0 all ones implies c_hi0 is clear, so the two carries never
    // both fire and an OR is an exact carry out.
    always_comb begin
        sum_p2_d  = {hi_inc, lo_sum_p1_q};
        cout_p2_d = c_hi0_p1_q | inc_cout;
`ifdef CIA_OVF_EN
        ovf_p2_d  = (sa_p1_q == sb_p1_q) && (hi_inc[CIA_HALF-1] != sa_p1_q);
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1_q     <= 1'b0;
            lo_sum_p1_q  <= '0;
            hi_sum0_p1_q <= '0;
            c_lo_p1_q    <= 1'b0;
            c_hi0_p1_q   <= 1'b0;
            vld_p2_q     <= 1'b0;
            sum_p2_q     <= '0;
            cout_p2_q    <= 1'b0;
`ifdef CIA_OVF_EN
            sa_p1_q      <= 1'b0;
            sb_p1_q      <= 1'b0;
            ovf_p2_q     <= 1'b0;
`endif
        end else begin
            if (adv1) begin
                vld_p1_q <= bus.in_valid;
                if (xfer) begin
                    lo_sum_p1_q  <= lo_sum_p1_d;
                    hi_sum0_p1_q <= hi_sum0_p1_d;
                    c_lo_p1_q    <= c_lo_p1_d;
                    c_hi0_p1_q   <= c_hi0_p1_d;
`ifdef CIA_OVF_EN
                    sa_p1_q      <= bus.a[CIA_WIDTH-1];
                    sb_p1_q      <= bus.b[CIA_WIDTH-1];
`endif
                end
            end
            if (adv2) begin
                vld_p2_q <= vld_p1_q;
                if (vld_p1_q) begin
                    sum_p2_q  <= sum_p2_d;
                    cout_p2_q <= cout_p2_d;
`ifdef CIA_OVF_EN
                    ovf_p2_q  <= ovf_p2_d;
`endif
                end
            end
        end
    end

endmodule : cia32_pipe

// File: tb/tb_cia32_pipe.sv
// -----------------------------------------------------------------------------
// tb_cia32_pipe
// Self-checking bench for cia32_pipe. A queue-based reference model computes
// each result as a plain 33-bit sum of the operands; every accepted operand
// beat is pushed, every delivered result beat is popped and compared.
// Optional feature macro: CIA_OVF_EN (overflow flag is checked when defined).
// -----------------------------------------------------------------------------
module tb_cia32_pipe;
    import cia_pkg::*;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    cia32_pipe_if bus ();

    cia32_pipe dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct packed {
        logic [31:0] sum;
        logic        cout;
        logic        ovf;
    } beat_t;

    beat_t exp_q[$];

    int n_pass  = 0;
    int n_total = 0;

    logic        stall_prev = 1'b0;
    logic [31:0] held_sum;
    logic        held_cout;
`ifdef CIA_OVF_EN
    logic        held_ovf;
`endif

    function automatic beat_t model(logic [31:0] a, logic [31:0] b, logic cin);
        logic [32:0] full;
        beat_t       r;
        full   = {1'b0, a} + {1'b0, b} + 33'(cin);
        r.sum  = full[31:0];
        r.cout = full[32];
        r.ovf  = (a[31] == b[31]) && (full[31] != a[31]);
        return r;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // One clock window: drive inputs, settle, check against the model, then
    // step to just after the next rising edge.
    task automatic cycle(input logic iv, input logic [31:0] a, input logic [31:0] b,
                         input logic ci, input logic ordy);
        beat_t e;
        bus.in_valid  = iv;
        bus.a         = a;
        bus.b         = b;
        bus.cin       = ci;
        bus.out_ready = ordy;
        #1;
        if (stall_prev) begin
            check("stall_valid_held", 64'(bus.out_valid), 64'd1);
            check("stall_sum_held", 64'(bus.sum), 64'(held_sum));
            check("stall_cout_held", 64'(bus.cout), 64'(held_cout));
`ifdef CIA_OVF_EN
            check("stall_ovf_held", 64'(bus.ovf), 64'(held_ovf));
`endif
        end
        // Two beats in flight fill both stages; then only a drain frees a slot.
        check("in_ready", 64'(bus.in_ready), 64'((exp_q.size() < 2) || ordy));
        stall_prev = bus.out_valid && !bus.out_ready;
        if (stall_prev) begin
            held_sum  = bus.sum;
            held_cout = bus.cout;
`ifdef CIA_OVF_EN
            held_ovf  = bus.ovf;
`endif
        end
        if (bus.out_valid && bus.out_ready) begin
            check("beat_expected", 64'(exp_q.size() != 0), 64'd1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("sum", 64'(bus.sum), 64'(e.sum));
                check("cout", 64'(bus.cout), 64'(e.cout));
`ifdef CIA_OVF_EN
                check("ovf", 64'(bus.ovf), 64'(e.ovf));
`endif
            end
        end
        if (bus.in_valid && bus.in_ready) exp_q.push_back(model(a, b, ci));
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input logic ordy);
        cycle(1'b0, 32'h0, 32'h0, 1'b0, ordy);
    endtask

    initial begin
        logic [31:0] ra, rb;
        logic        riv, rci, rrdy;
        int          mode;

        bus.in_valid  = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.cin       = 1'b0;
        bus.out_ready = 1'b0;

        // Reset state
        #1;
        check("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("rst_sum", 64'(bus.sum), 64'd0);
        check("rst_cout", 64'(bus.cout), 64'd0);
        check("rst_in_ready", 64'(bus.in_ready), 64'd1);
`ifdef CIA_OVF_EN
        check("rst_ovf", 64'(bus.ovf), 64'd0);
`endif
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Two-cycle latency with the low-half carry crossing into the upper half
        cycle(1'b1, 32'h0000FFFF, 32'h00000001, 1'b0, 1'b1);
        check("lat_w1_out_valid", 64'(bus.out_valid), 64'd0);
        idle(1'b1);
        check("lat_w2_out_valid", 64'(bus.out_valid), 64'd1);
        check("lat_w2_sum", 64'(bus.sum), 64'h00010000);
        check("lat_w2_cout", 64'(bus.cout), 64'd0);
        idle(1'b1);

        // Directed carry and overflow corners, streamed back to back
        cycle(1'b1, 32'hFFFFFFFF, 32'h00000000, 1'b1, 1'b1);
        cycle(1'b1, 32'h80000000, 32'h80000000, 1'b0, 1'b1);
        cycle(1'b1, 32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b1);
        cycle(1'b1, 32'h00000001, 32'h00000002, 1'b0, 1'b1);
        idle(1'b1);
        idle(1'b1);
        idle(1'b1);

        // Backpressure: two accepted, third refused, then drain + accept together
        cycle(1'b1, 32'h11112222, 32'h33334444, 1'b0, 1'b0);
        cycle(1'b1, 32'h0000FFFF, 32'hFFFF0001, 1'b1, 1'b0);
        check("stall_full_in_ready", 64'(bus.in_ready), 64'd0);
        cycle(1'b1, 32'hDEADBEEF, 32'h21524111, 1'b1, 1'b0);
        cycle(1'b1, 32'hDEADBEEF, 32'h21524111, 1'b1, 1'b0);
        cycle(1'b1, 32'hDEADBEEF, 32'h21524111, 1'b1, 1'b1);
        idle(1'b1);
        idle(1'b1);
        idle(1'b1);
        check("stall_drained", 64'(exp_q.size()), 64'd0);

        // Randomized traffic with random backpressure and carry-chain bias
        for (int i = 0; i < 400; i++) begin
            ra   = $urandom;
            rb   = $urandom;
            rci  = 1'($urandom_range(0, 1));
            mode = $urandom_range(0, 3);
            if (mode == 1) rb = ~ra;
            if (mode == 2) begin
                ra[15:0] = 16'hFFFF;
                rb[15:0] = 16'h0000;
            end
            riv  = ($urandom_range(0, 3) != 0);
            rrdy = ($urandom_range(0, 2) != 0);
            cycle(riv, ra, rb, rci, rrdy);
        end
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) idle(1'b1);
        check("random_drained", 64'(exp_q.size()), 64'd0);

        // Asynchronous reset with two beats in flight
        cycle(1'b1, 32'h01020304, 32'h05060708, 1'b0, 1'b0);
        cycle(1'b1, 32'hFFFF0000, 32'h0000FFFF, 1'b1, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_out_valid", 64'(bus.out_valid), 64'd0);
        check("arst_sum", 64'(bus.sum), 64'd0);
        check("arst_cout", 64'(bus.cout), 64'd0);
`ifdef CIA_OVF_EN
        check("arst_ovf", 64'(bus.ovf), 64'd0);
`endif
        exp_q.delete();
        stall_prev = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // First beat after reset release: exactly two cycles to out_valid
        cycle(1'b1, 32'h12345678, 32'h11111111, 1'b1, 1'b1);
        check("post_rst_w1_out_valid", 64'(bus.out_valid), 64'd0);
        idle(1'b1);
        check("post_rst_w2_out_valid", 64'(bus.out_valid), 64'd1);
        check("post_rst_w2_sum", 64'(bus.sum), 64'h2345678A);
        idle(1'b1);
        idle(1'b1);
        check("final_drained", 64'(exp_q.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule : tb_cia32_pipe
